fpga_config_loader: RTL and testbench

FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

---
 rtl/fpga_cfg_pkg.sv | 29 ++
 rtl/cfg_delay_counter.sv | 40 ++++
 rtl/fpga_config_loader.sv | 164 ++++++++++++++++
 tb/tb_fpga_config_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared definitions for the FPGA configuration loader:
//   - default parameter values (word width, column count, settle time)
//   - loader FSM state encoding
//   - idx_width(): width of the column index register
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

    localparam int DEF_WORD_W        = 224;
    localparam int DEF_NUM_WORDS     = 245;
    localparam int DEF_SETTLE_CYCLES = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        SETTLE = 3'd3,
        ENABLE = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // Column index width; a single-column fabric still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// ---------------------------------------------------------------------------
// cfg_delay_counter
// Counts CYCLES enabled cycles after a load and flags the last one.
//   clock    : rising-edge clock
//   rst      : asynchronous active-low reset
//   i_load   : clear the count (takes priority over i_count)
//   i_count  : advance the count this cycle
//   o_done   : high during the CYCLES-th enabled cycle since the last load
// CYCLES must be at least 1.
// ---------------------------------------------------------------------------
module cfg_delay_counter #(
    parameter int CYCLES = 10
) (
    input  logic clock,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_done
);

    localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Combinational so the FSM can leave its wait state on exactly the
    // CYCLES-th cycle instead of one later.
    assign o_done = i_count && (r_cnt == TERM);

endmodule

// File: rtl/fpga_config_loader.sv
// ---------------------------------------------------------------------------
// fpga_config_loader
// Streams a bitstream of NUM_WORDS words into the fabric configuration
// columns, one column per accepted word, then waits SETTLE_CYCLES cycles and
// enables the fabric flip-flops.
//   clock       : rising-edge clock
//   rst         : asynchronous active-low reset
//   start       : one-cycle load request (honoured in IDLE/DONE/ERROR only)
//   in_valid    : bitstream word valid
//   in_data     : bitstream word
//   in_last     : final word marker, qualified by in_valid
//   in_ready    : loader accepts in_data this cycle
//   configs_in  : data to the configuration column
//   configs_en  : one-hot column write strobe
//   ff_en       : fabric flip-flop enable
//   rdy         : fabric configured and running
//   busy        : load in progress
//   err         : sticky length-mismatch flag
//   o_dbg_state : current FSM state
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is a registered output that is 1 only in LOAD, so it
// never depends combinationally on in_valid; the source may hold in_valid
// low for any number of cycles and must hold in_data/in_last stable until
// the transfer happens.
// ---------------------------------------------------------------------------
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int NUM_WORDS     = DEF_NUM_WORDS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [WORD_W-1:0]    configs_in,
    output logic [NUM_WORDS-1:0] configs_en,
    output logic                 ff_en,
    output logic                 rdy,
    output logic                 busy,
    output logic                 err,
    output state_t               o_dbg_state
);

    localparam int               IW       = idx_width(NUM_WORDS);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] EN_BIT0 = NUM_WORDS'(1);

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [WORD_W-1:0]     r_cfg_in;
    logic [NUM_WORDS-1:0]  r_cfg_en;
    logic                  r_in_ready;
    logic                  r_ff_en;
    logic                  r_rdy;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_last;     // in_last of the word being written
    logic                  r_at_end;   // word being written targets the last column

    logic                  w_cnt_load;
    logic                  w_cnt_en;
    logic                  w_settle_done;

    // The counter is held clear everywhere except SETTLE, so every entry to
    // SETTLE starts from zero.
    assign w_cnt_load = (r_state != SETTLE);
    assign w_cnt_en   = (r_state == SETTLE);

    cfg_delay_counter #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clock   (clock),
        .rst     (rst),
        .i_load  (w_cnt_load),
        .i_count (w_cnt_en),
        .o_done  (w_settle_done)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cfg_in   <= '0;
            r_cfg_en   <= '0;
            r_in_ready <= 1'b0;
            r_ff_en    <= 1'b0;
            r_rdy      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
            r_at_end   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_idx      <= '0;
                        r_err      <= 1'b0;
                        r_ff_en    <= 1'b0;
                        r_rdy      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_cfg_in   <= in_data;
                        r_cfg_en   <= EN_BIT0 << r_idx;
                        r_last     <= in_last;
                        r_at_end   <= (r_idx == LAST_IDX);
                        r_in_ready <= 1'b0;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    r_cfg_en <= '0;
                    if (r_last && r_at_end) begin
                        r_state <= SETTLE;
                    end else if (r_last || r_at_end) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ERROR;
                    end else begin
                        // Only advanced when another word follows, so idx
                        // cannot step past the last column.
                        r_idx      <= r_idx + IW'(1);
                        r_in_ready <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        r_ff_en <= 1'b1;
                        r_state <= ENABLE;
                    end
                end
                ENABLE: begin
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign configs_in  = r_cfg_in;
    assign configs_en  = r_cfg_en;
    assign ff_en       = r_ff_en;
    assign rdy         = r_rdy;
    assign busy        = r_busy;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fpga_config_loader.sv
// ---------------------------------------------------------------------------
// tb_fpga_config_loader
// Scenario table drives full/partial loads; a negedge monitor logs every
// column strobe and checks one-hot, single-cycle width and data. Hand-written
// sequences cover reset state and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_fpga_config_loader;
    import fpga_cfg_pkg::*;

    localparam int WW = 224;
    localparam int NW = 245;
    localparam int SC = 10;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data  = '0;
    logic          in_last  = 1'b0;
    logic          in_ready;
    logic [WW-1:0] configs_in;
    logic [NW-1:0] configs_en;
    logic          ff_en;
    logic          rdy;
    logic          busy;
    logic          err;
    state_t        dbg_state;

    always #5 clock = ~clock;

    fpga_config_loader #(
        .WORD_W        (WW),
        .NUM_WORDS     (NW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .configs_in  (configs_in),
        .configs_en  (configs_en),
        .ff_en       (ff_en),
        .rdy         (rdy),
        .busy        (busy),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bitstream word k is the byte k replicated across the word.
    function automatic logic [WW-1:0] word_of(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {(WW/8){b}};
    endfunction

    // ---------------- scenario table ----------------
    typedef struct {
        int n_words;   // words the loader is expected to accept
        int last_pos;  // word carrying in_last, -1 for none
        bit stall;     // randomise in_valid
        int start_at;  // word during which start is pulsed, -1 for none
        bit exp_err;
        bit exp_rdy;
    } scen_t;

    localparam int NSCEN = 6;
    scen_t tbl [NSCEN];

    // ---------------- monitor / scoreboard ----------------
    logic [WW-1:0] exp_q [$];   // expected data per column, filled per scenario
    int obs_q [$];              // observed column indices in strobe order
    int cyc = 0;
    int last_pulse = -1;
    int ff_rise = -1;
    int rdy_rise = -1;
    logic prev_en_nz = 1'b0;
    logic prev_ff    = 1'b0;
    logic prev_rdy   = 1'b0;

    always @(negedge clock) begin : monitor
        int col;
        cyc++;
        if (configs_en != '0) begin
            col = -1;
            for (int i = 0; i < NW; i++) begin
                if (configs_en[i]) col = i;
            end
            check("en_onehot", $countones(configs_en), 1);
            check("en_single_cycle", int'(prev_en_nz), 0);
            check_w("cfg_data", configs_in, word_of(col));
            obs_q.push_back(col);
            last_pulse = cyc;
        end
        if (ff_en && !prev_ff) ff_rise = cyc;
        if (rdy && !prev_rdy) rdy_rise = cyc;
        prev_en_nz = (configs_en != '0);
        prev_ff    = ff_en;
        prev_rdy   = rdy;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present words 0..n-1; a word advances only when in_valid and in_ready
    // are both high at a negedge (the following posedge takes it).
    task automatic send_words(input int n, input int last_pos, input bit stall,
                              input int start_at, output bit ok);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < n && guard < 5000) begin
            @(negedge clock);
            guard++;
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = word_of(k);
            in_last  = (k == last_pos);
            start    = (k == start_at);
            if (in_valid && in_ready) k++;
        end
        ok = (k == n);
        @(negedge clock);
        start   = 1'b0;
        in_last = 1'b0;
        in_data = word_of(k);
        in_valid = 1'b1;   // keep offering data: nothing more may be taken
    endtask

    task automatic run_scen(input int s);
        scen_t t;
        bit ok;
        int bad_col;
        t = tbl[s];
        pulse_start();
        check("start_ff_en", int'(ff_en), 0);
        check("start_rdy", int'(rdy), 0);
        check("start_err", int'(err), 0);
        check("start_busy", int'(busy), 1);
        check("start_in_ready", int'(in_ready), 1);
        check("start_state", int'(dbg_state), int'(LOAD));
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < t.n_words; i++) exp_q.push_back(word_of(i));
        last_pulse = -1;
        ff_rise = -1;
        rdy_rise = -1;

        send_words(t.n_words, t.last_pos, t.stall, t.start_at, ok);
        check("accept_timeout", int'(ok), 1);

        for (int i = 0; i < 60 && !(rdy || err); i++) @(negedge clock);
        repeat (4) @(negedge clock);
        in_valid = 1'b0;

        check("col_count", obs_q.size(), exp_q.size());
        bad_col = -1;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (bad_col < 0 && obs_q[i] != i) bad_col = i;
        end
        check("col_order_first_bad", bad_col, -1);
        check("end_err", int'(err), int'(t.exp_err));
        check("end_rdy", int'(rdy), int'(t.exp_rdy));
        check("end_ff_en", int'(ff_en), int'(t.exp_rdy));
        check("end_busy", int'(busy), 0);
        check("end_in_ready", int'(in_ready), 0);
        check("end_state", int'(dbg_state), t.exp_rdy ? int'(DONE) : int'(ERROR));
        if (t.exp_rdy) begin
            // Strobe seen at negedge N; the WRITE cycle ends one cycle later,
            // and SETTLE_CYCLES cycles after that ff_en is seen.
            check("ff_en_delay", ff_rise - last_pulse, SC + 1);
            check("rdy_delay", rdy_rise - ff_rise, 1);
        end else begin
            check("ff_en_never", ff_rise, -1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        //            n    last  stall start_at err rdy
        tbl[0] = '{245, 244, 1'b0,   -1, 1'b0, 1'b1};  // nominal from IDLE
        tbl[1] = '{245, 244, 1'b0,  120, 1'b0, 1'b1};  // start from DONE, start pulsed mid-load
        tbl[2] = '{245, 244, 1'b1,   -1, 1'b0, 1'b1};  // backpressure
        tbl[3] = '{101, 100, 1'b0,   -1, 1'b1, 1'b0};  // early last on word 100
        tbl[4] = '{245,  -1, 1'b0,   -1, 1'b1, 1'b0};  // missing last, start clears err
        tbl[5] = '{  1,   0, 1'b1,   -1, 1'b1, 1'b0};  // last on the very first word

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", int'(dbg_state), int'(IDLE));
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_en", int'(configs_en != '0), 0);
        check_w("rst_cfg_in", configs_in, '0);
        check("rst_ff_rdy_err", int'({ff_en, rdy, err}), 0);
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_no_start_state", int'(dbg_state), int'(IDLE));
        check("idle_no_start_en", int'(configs_en != '0), 0);
        in_valid = 1'b0;

        for (int s = 0; s < NSCEN; s++) run_scen(s);

        // Reset in the middle of a load, during the WRITE of word 49
        begin : mid_reset
            bit ok;
            pulse_start();
            send_words(50, -1, 1'b0, -1, ok);
            check("mid_accept_timeout", int'(ok), 1);
            #2;
            rst = 1'b0;
            #1;
            check("mid_rst_state", int'(dbg_state), int'(IDLE));
            check("mid_rst_en", int'(configs_en != '0), 0);
            check_w("mid_rst_cfg_in", configs_in, '0);
            check("mid_rst_busy", int'(busy), 0);
            check("mid_rst_in_ready", int'(in_ready), 0);
            check("mid_rst_ff_rdy_err", int'({ff_en, rdy, err}), 0);
            in_valid = 1'b0;
            repeat (2) @(negedge clock);
            rst = 1'b1;
            repeat (2) @(negedge clock);
            check("post_rst_idle", int'(dbg_state), int'(IDLE));
        end

        // Reload after reset must begin at column 0 and complete.
        run_scen(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
